// File: rtl/subservient_loader_pkg.sv
// Shared types and constants for the subservient UART boot loader.
// The S_CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package subservient_loader_pkg;

  localparam int         CSUM_W = 8;
  localparam logic [3:0] WB_SEL = 4'b1111;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd2,
`endif
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Little-endian byte insertion into a 32-bit word at the given lane.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res        = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/subservient_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start detection, one-cycle valid / frame_err pulses.
module subservient_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int               TMR_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  rx_state_e        state_q, state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Receiver next-state: bit timer, shift register and result pulses
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        // A line that is high again at mid start bit was only a glitch
        if (tmr_q == HALF_M1) begin
          tmr_d = '0;
          bit_d = 3'd0;
          if (rx_sync_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RX_DATA: begin
        if (tmr_q == FULL_M1) begin
          tmr_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RX_STOP: begin
        if (tmr_q == FULL_M1) begin
          tmr_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Receiver state registers; the synchronizer resets to the idle-high level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      tmr_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_byte      = shift_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/subservient_uart_loader.sv
// UART boot loader feeding the subservient Wishbone debug port.
// Optional trailing checksum byte is enabled with LOADER_CHECKSUM_EN.
module subservient_uart_loader
  import subservient_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          MEMSIZE      = 8192,
  parameter logic [31:0] BASE_ADR     = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  output logic        o_done,
  output logic        o_error
);

  localparam int          CNT_W     = $clog2(MEMSIZE) + 1;
  localparam logic [31:0] MEMSIZE_W = 32'(MEMSIZE);

  logic [CSUM_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  state_e             state_q, state_d;
  logic [31:0]        len_q, len_d;
  logic [1:0]         len_idx_q, len_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               stb_q, stb_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               debug_q, debug_d;
`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]  csum_q, csum_d;
`endif

  logic               ack_hs;
  logic               last_byte;
  logic [31:0]        word_full;
  logic [31:0]        len_nxt;
  logic [31:0]        word_adr;

  subservient_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_byte      (rx_byte),
    .o_valid     (rx_valid),
    .o_frame_err (rx_ferr)
  );

  assign ack_hs    = stb_q & i_wb_dbg_ack;
  assign last_byte = ((cnt_q + CNT_W'(1)) == len_q[CNT_W-1:0]);
  assign word_full = place_byte(word_q, rx_byte, cnt_q[1:0]);
  assign len_nxt   = place_byte(len_q, rx_byte, len_idx_q);
  assign word_adr  = BASE_ADR + {{(32-CNT_W){1'b0}}, cnt_q[CNT_W-1:2], 2'b00};

  // Loader FSM, byte packing and write-buffer control
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    len_idx_d = len_idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (ack_hs) begin
      stb_d = 1'b0;
    end else begin
      stb_d = stb_q;
    end

    case (state_q)
      S_LEN: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          len_d     = len_nxt;
          len_idx_d = len_idx_q + 2'd1;
          if (len_idx_q != 2'd3) begin
            state_d = S_LEN;
          end else if (len_nxt > MEMSIZE_W) begin
            state_d = S_ERR;
          end else if (len_nxt == 32'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_byte;
`endif
          if ((cnt_q[1:0] == 2'b11) || last_byte) begin
            word_d = 32'h0;
            // Buffer is free if empty or being acknowledged on this very edge
            if (stb_q && !ack_hs) begin
              state_d = S_ERR;
            end else begin
              stb_d = 1'b1;
              adr_d = word_adr;
              dat_d = word_full;
              if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CSUM;
`else
                state_d = S_DRAIN;
`endif
              end else begin
                state_d = S_DATA;
              end
            end
          end else begin
            word_d  = word_full;
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if (rx_byte != csum_q) begin
            state_d = S_ERR;
          end else if (!stb_q || ack_hs) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DRAIN: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (!stb_q || ack_hs) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
    debug_d = (state_d != S_DONE);
  end

  // Loader state, write buffer and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_LEN;
      len_q     <= 32'h0;
      len_idx_q <= 2'd0;
      cnt_q     <= '0;
      word_q    <= 32'h0;
      adr_q     <= BASE_ADR;
      dat_q     <= 32'h0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      debug_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      len_idx_q <= len_idx_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      done_q    <= done_d;
      error_q   <= error_d;
      debug_q   <= debug_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_debug_mode = debug_q;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_wb_dbg_sel = WB_SEL;
  assign o_wb_dbg_we  = 1'b1;
  assign o_wb_dbg_stb = stb_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule
